// File: rtl/fetch_pc_queue.sv
// Instruction-fetch stage: PC register plus a DEPTH-entry IF->ID queue so fetch
// can run ahead of a stalled decode. Redirect priority: exception, eret, branch.
module fetch_pc_queue #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000,
  parameter logic [ADDR_W-1:0] EXC_PC   = 32'h0000_4180,
  parameter int                DEPTH    = 4,
  localparam int               PW       = $clog2(DEPTH),
  localparam int               CW       = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              exc_req,
  input  logic              eret_req,
  input  logic [ADDR_W-1:0] epc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              deq_ready,
  output logic              deq_valid,
  output logic [ADDR_W-1:0] deq_pc,
  output logic [31:0]       deq_instr,
  output logic              deq_adel,
  output logic [CW-1:0]     count
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       instr;
    logic              adel;
  } entry_t;

  entry_t            storage [DEPTH];
  logic [ADDR_W-1:0] pc_q;
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic              halt;

  logic   flush, pop, full, fetch, adel;
  entry_t head, wr_entry;

  assign flush    = exc_req | eret_req | redirect_valid;
  assign pop      = deq_valid & deq_ready;
  assign full     = (count == CW'(DEPTH));
  assign fetch    = !flush && !halt && (!full || pop);
  assign adel     = |pc_q[1:0];
  assign wr_entry = '{pc: pc_q, instr: (adel ? 32'h0 : imem_rdata), adel: adel};

  assign imem_addr = pc_q;

  // Head is masked when empty so stale storage never reaches decode.
  assign head      = storage[rd_ptr];
  assign deq_valid = (count != '0);
  assign deq_pc    = deq_valid ? head.pc    : '0;
  assign deq_instr = deq_valid ? head.instr : '0;
  assign deq_adel  = deq_valid ? head.adel  : 1'b0;

  always_ff @(posedge clk) begin
    if (fetch) storage[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      halt   <= 1'b0;
    end else if (flush) begin
      // A pop in this cycle is consumed by ID; everything else is discarded.
      if (exc_req)       pc_q <= EXC_PC;
      else if (eret_req) pc_q <= epc;
      else               pc_q <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      halt   <= 1'b0;
    end else begin
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (fetch) begin
        wr_ptr <= wr_ptr + 1'b1;
        // A misaligned fetch parks the PC until the next redirect.
        if (adel) halt <= 1'b1;
        else      pc_q <= pc_q + ADDR_W'(4);
      end
      count <= count + CW'(fetch) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Directed bench for fetch_pc_queue: reset, streaming, backpressure, redirects,
// misaligned halt, address wrap and a pointer-wrap scoreboard.
module tb_fetch_pc_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_req, eret_req, redirect_valid, deq_ready;
  logic [31:0] epc, redirect_pc, imem_addr, imem_rdata;
  logic        deq_valid, deq_adel;
  logic [31:0] deq_pc, deq_instr;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_pc_queue dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .eret_req(eret_req), .epc(epc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .deq_ready(deq_ready),
    .deq_valid(deq_valid), .deq_pc(deq_pc), .deq_instr(deq_instr),
    .deq_adel(deq_adel), .count(count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [31:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] pat;
    logic [31:0] exp_pc;
    int pops;

    reset = 1'b1; exc_req = 1'b0; eret_req = 1'b0; redirect_valid = 1'b0;
    deq_ready = 1'b0; epc = '0; redirect_pc = '0;
    tick(); tick();
    chk("rst_valid", 32'(deq_valid), 0);
    chk("rst_pc",    deq_pc, 0);
    chk("rst_instr", deq_instr, 0);
    chk("rst_adel",  32'(deq_adel), 0);
    chk("rst_imem",  imem_addr, 32'h3000);
    chk("rst_count", 32'(count), 0);

    // Free run: one entry in flight, consumed every cycle.
    reset = 1'b0; deq_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("run_pc",    deq_pc, 32'h3000 + 32'(4*k));
      chk("run_instr", deq_instr, mem_word(32'h3000 + 32'(4*k)));
      chk("run_count", 32'(count), 1);
    end

    // Backpressure: fills with 3008..3014, PC parks at 3018.
    deq_ready = 1'b0;
    repeat (8) tick();
    chk("full_count", 32'(count), 4);
    chk("full_imem",  imem_addr, 32'h3018);
    chk("full_head",  deq_pc, 32'h3008);
    deq_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fullpop_pc",    deq_pc, 32'h300C + 32'(4*k));
      chk("fullpop_count", 32'(count), 4);
    end
    chk("fullpop_imem", imem_addr, 32'h3028);

    // Exception beats branch in the same cycle.
    deq_ready = 1'b0; exc_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3400;
    tick();
    exc_req = 1'b0; redirect_valid = 1'b0;
    chk("exc_count", 32'(count), 0);
    chk("exc_valid", 32'(deq_valid), 0);
    chk("exc_imem",  imem_addr, 32'h4180);
    tick();
    chk("exc_pc",    deq_pc, 32'h4180);
    chk("exc_cnt1",  32'(count), 1);
    tick();
    eret_req = 1'b1; epc = 32'h3020;
    tick();
    eret_req = 1'b0;
    chk("eret_imem",  imem_addr, 32'h3020);
    chk("eret_count", 32'(count), 0);
    tick();
    chk("eret_pc", deq_pc, 32'h3020);

    // Misaligned target: one tagged entry, then fetch halts.
    redir(32'h3002);
    chk("adel_imem0", imem_addr, 32'h3002);
    tick();
    chk("adel_pc",    deq_pc, 32'h3002);
    chk("adel_flag",  32'(deq_adel), 1);
    chk("adel_instr", deq_instr, 0);
    chk("adel_count", 32'(count), 1);
    repeat (3) tick();
    chk("halt_count", 32'(count), 1);
    chk("halt_imem",  imem_addr, 32'h3002);
    deq_ready = 1'b1;
    tick();
    chk("halt_drain", 32'(count), 0);
    chk("halt_imem2", imem_addr, 32'h3002);
    deq_ready = 1'b0;
    redir(32'h3100);
    tick();
    chk("unhalt_pc",    deq_pc, 32'h3100);
    chk("unhalt_adel",  32'(deq_adel), 0);
    chk("unhalt_instr", deq_instr, mem_word(32'h3100));

    // Address wrap.
    deq_ready = 1'b1;
    redir(32'hFFFF_FFFC);
    tick();
    chk("wrap_pc0", deq_pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc1", deq_pc, 32'h0000_0000);

    // Scoreboard over many pushes with irregular consumption.
    deq_ready = 1'b0;
    redir(32'h0000_0200);
    pat = 32'b1011_0110_1110_0101_1001_1101_0111_0011;
    exp_pc = 32'h200;
    pops = 0;
    for (int i = 0; i < 48; i++) begin
      deq_ready = pat[i % 32];
      #1;
      if (deq_valid && deq_ready) begin
        chk("sb_pc",    deq_pc, exp_pc);
        chk("sb_instr", deq_instr, mem_word(exp_pc));
        exp_pc += 4;
        pops++;
      end
      chk("sb_count_le", 32'(count <= 3'd4), 1);
      tick();
    end
    chk("sb_pops", 32'(pops >= 13), 1);

    // Reset while full with a simultaneous redirect.
    deq_ready = 1'b0;
    repeat (5) tick();
    chk("pre_rst_full", 32'(count), 4);
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3400;
    tick();
    reset = 1'b0; redirect_valid = 1'b0;
    chk("rst2_imem",  imem_addr, 32'h3000);
    chk("rst2_count", 32'(count), 0);
    chk("rst2_valid", 32'(deq_valid), 0);
    tick();
    chk("rst2_pc",    deq_pc, 32'h3000);
    chk("rst2_cnt1",  32'(count), 1);

    // Reset while halted.
    redir(32'h3002);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst3_imem",  imem_addr, 32'h3000);
    chk("rst3_count", 32'(count), 0);
    tick();
    chk("rst3_pc",   deq_pc, 32'h3000);
    chk("rst3_adel", 32'(deq_adel), 0);
    chk("rst3_imem2", imem_addr, 32'h3004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
